// File: rtl/iq_fm_discriminator_pkg.sv
// iq_fm_disc_pkg: shared types and constants for the IQ FM discriminator.
//  - state_t     : FSM state encoding
//  - K_Q15       : CORDIC gain compensation, round(0.60725 * 2^15)
//  - FRAC_BITS   : fractional bits carried below the sample LSB in x/y
//  - atan_lut()  : atan(2^-k) as a fraction of a turn, scaled to 2^pw
// Optional feature macro used by the block: IQ_FM_DISC_MAG_EN.
package iq_fm_disc_pkg;

  typedef enum logic [1:0] {IDLE, PRE, ITER, POST} state_t;

  localparam int K_Q15 = 19898;

  // Without sub-LSB precision the residual y after the late micro-rotations
  // quantises to whole sample LSBs and the phase error grows to ~10 LSB.
  localparam int FRAC_BITS = 4;

  // atan(2^-k) / (2*pi) * 2^32, k = 0..31
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // Rounded to a pw-bit circle; pw must be below 32.
  function automatic logic [31:0] atan_lut(input logic [4:0] k, input int pw);
    logic [31:0] a;
    a = ATAN32[k];
    return (a + (32'd1 << (31 - pw))) >> (32 - pw);
  endfunction

endpackage

// File: rtl/iq_fm_discriminator_if.sv
// iq_fm_discriminator_if: sample/result bundle of the FM discriminator.
//  in_valid, i_in, q_in : upstream sample strobe and signed I/Q
//  in_ready             : discriminator idle and able to accept
//  out_valid            : one-cycle result strobe
//  phase_out, freq_out  : phase (turn fraction) and phase step
//  overrun              : sticky dropped-sample flag
//  mag_out              : magnitude, only with IQ_FM_DISC_MAG_EN
// master = sample source / result sink, slave = discriminator.
interface iq_fm_discriminator_if #(
  parameter int IN_WIDTH    = 12,
  parameter int PHASE_WIDTH = 16
);
  logic                          in_valid;
  logic signed [IN_WIDTH-1:0]    i_in;
  logic signed [IN_WIDTH-1:0]    q_in;
  logic                          in_ready;
  logic                          out_valid;
  logic        [PHASE_WIDTH-1:0] phase_out;
  logic        [PHASE_WIDTH-1:0] freq_out;
  logic                          overrun;
`ifdef IQ_FM_DISC_MAG_EN
  logic        [IN_WIDTH:0]      mag_out;

  modport master (output in_valid, i_in, q_in,
                  input  in_ready, out_valid, phase_out, freq_out, overrun, mag_out);
  modport slave  (input  in_valid, i_in, q_in,
                  output in_ready, out_valid, phase_out, freq_out, overrun, mag_out);
`else
  modport master (output in_valid, i_in, q_in,
                  input  in_ready, out_valid, phase_out, freq_out, overrun);
  modport slave  (input  in_valid, i_in, q_in,
                  output in_ready, out_valid, phase_out, freq_out, overrun);
`endif
endinterface

// File: rtl/iq_fm_discriminator_cordic_vec_iter.sv
// cordic_vec_iter: one vectoring-mode CORDIC micro-rotation, combinational.
//  x, y  : current vector (signed, XW bits)
//  z     : accumulated angle (PW-bit turn fraction)
//  k     : micro-rotation index
//  x_nx, y_nx, z_nx : vector and angle after rotation k
// Rotates towards y = 0; y >= 0 counts as positive.
module cordic_vec_iter
  import iq_fm_disc_pkg::*;
#(
  parameter int XW = 18,
  parameter int PW = 16,
  parameter int KW = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic        [PW-1:0] z,
  input  logic        [KW-1:0] k,
  output logic signed [XW-1:0] x_nx,
  output logic signed [XW-1:0] y_nx,
  output logic        [PW-1:0] z_nx
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [PW-1:0] ang;

  always_comb begin
    x_sh = x >>> k;
    y_sh = y >>> k;
    ang  = PW'(atan_lut(5'(k), PW));
    if (y[XW-1]) begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - ang;
    end else begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + ang;
    end
  end

endmodule

// File: rtl/iq_fm_discriminator.sv
// iq_fm_discriminator: iterative CORDIC phase extractor and FM discriminator.
//  clk  : single clock
//  RST  : asynchronous, active-high reset
//  bus  : iq_fm_discriminator_if.slave (sample in, phase/freq out, overrun)
// One sample per ITERATIONS+3 cycles; results appear ITERATIONS+3 edges after
// the edge that accepts the sample. Define IQ_FM_DISC_MAG_EN to add mag_out.
//
//  state | meaning
//  IDLE  | waiting for in_valid; capture sign-extended I/Q
//  PRE   | fold left half-plane into right half-plane (z = 0 or 1/2 turn)
//  ITER  | one micro-rotation per cycle, k = 0..ITERATIONS-1
//  POST  | commit phase, phase step and magnitude for the output stage
module iq_fm_discriminator
  import iq_fm_disc_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 14
) (
  input logic               clk,
  input logic               RST,
  iq_fm_discriminator_if.slave bus
);

  localparam int XW = IN_WIDTH + 2 + FRAC_BITS;
  localparam int KW = $clog2(ITERATIONS);
  localparam logic [KW-1:0] K_LAST = KW'(ITERATIONS - 1);

  state_t                  state, state_nx;
  logic signed [XW-1:0]    x_q, y_q, x_nx, y_nx;
  logic [PHASE_WIDTH-1:0]  z_q, z_nx, z_sel;
  logic [PHASE_WIDTH-1:0]  phase_prev, freq_q, phase_out_q, freq_out_q;
  logic [KW-1:0]           k_q;
  logic                    zero_q, prime_q, pend_q, out_valid_q, overrun_q;
  logic                    in_ready_c;

  cordic_vec_iter #(.XW(XW), .PW(PHASE_WIDTH), .KW(KW)) u_iter (
    .x(x_q), .y(y_q), .z(z_q), .k(k_q),
    .x_nx(x_nx), .y_nx(y_nx), .z_nx(z_nx)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = PRE;
      PRE:     state_nx = ITER;
      ITER:    if (k_q == K_LAST) state_nx = POST;
      POST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state == IDLE);
  end

  // An all-zero vector has no phase; reuse the previous one so freq reads 0.
  assign z_sel = zero_q ? phase_prev : z_q;

`ifdef IQ_FM_DISC_MAG_EN
  localparam int PRODW = XW + 16;
  logic [PRODW-1:0] mag_prod;
  logic [IN_WIDTH:0] mag_q, mag_out_q;
  // x is non-negative after PRE and every rotation keeps it so.
  assign mag_prod = PRODW'($unsigned(x_q)) * PRODW'(K_Q15);
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      k_q         <= '0;
      zero_q      <= 1'b0;
      prime_q     <= 1'b0;
      phase_prev  <= '0;
      freq_q      <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      phase_out_q <= '0;
      freq_out_q  <= '0;
      overrun_q   <= 1'b0;
`ifdef IQ_FM_DISC_MAG_EN
      mag_q       <= '0;
      mag_out_q   <= '0;
`endif
    end else begin
      pend_q      <= 1'b0;
      out_valid_q <= pend_q;
      if (pend_q) begin
        phase_out_q <= phase_prev;
        freq_out_q  <= freq_q;
`ifdef IQ_FM_DISC_MAG_EN
        mag_out_q   <= mag_q;
`endif
      end
      if (bus.in_valid && !in_ready_c) overrun_q <= 1'b1;

      case (state)
        IDLE: if (bus.in_valid) begin
          x_q    <= {{2{bus.i_in[IN_WIDTH-1]}}, bus.i_in, {FRAC_BITS{1'b0}}};
          y_q    <= {{2{bus.q_in[IN_WIDTH-1]}}, bus.q_in, {FRAC_BITS{1'b0}}};
          zero_q <= (bus.i_in == '0) && (bus.q_in == '0);
        end
        PRE: begin
          k_q <= '0;
          if (x_q[XW-1]) begin
            x_q <= -x_q;
            y_q <= -y_q;
            z_q <= {1'b1, {(PHASE_WIDTH-1){1'b0}}};
          end else begin
            z_q <= '0;
          end
        end
        ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          k_q <= k_q + KW'(1);
        end
        POST: begin
          phase_prev <= z_sel;
          freq_q     <= prime_q ? (z_sel - phase_prev) : '0;
          prime_q    <= 1'b1;
          pend_q     <= 1'b1;
`ifdef IQ_FM_DISC_MAG_EN
          mag_q      <= (IN_WIDTH+1)'(mag_prod >> (15 + FRAC_BITS));
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.phase_out = phase_out_q;
  assign bus.freq_out  = freq_out_q;
  assign bus.overrun   = overrun_q;
`ifdef IQ_FM_DISC_MAG_EN
  assign bus.mag_out   = mag_out_q;
`endif

endmodule

// File: tb/tb_iq_fm_discriminator.sv
// Self-checking bench for iq_fm_discriminator. Expected phase/freq/magnitude
// come from a floating-point atan2/sqrt model of each driven sample and are
// queued; the monitor pops one entry per out_valid pulse.
module tb_iq_fm_discriminator;

  localparam int  IW  = 12;
  localparam int  PW  = 16;
  localparam int  IT  = 14;
  localparam int  LAT = IT + 3;
  localparam real TWO_PI = 6.283185307179586;
  localparam real DEG    = 0.017453292519943295;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_fm_discriminator_if #(.IN_WIDTH(IW), .PHASE_WIDTH(PW)) bus();

  iq_fm_discriminator #(.IN_WIDTH(IW), .PHASE_WIDTH(PW), .ITERATIONS(IT)) dut (
    .clk(clk), .RST(rst), .bus(bus)
  );

  typedef struct {
    int phase; int ptol;
    int freq;  int ftol;
    int mag;   int mtol;
    int issue;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ov_total = 0;
  int   m_prev = 0;
  bit   m_prime = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Difference taken modulo 2^16 so phase/freq wrap compares correctly.
  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    d = int'($signed(16'(got - exp)));
    n_chk++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic exp_t model(input int i, input int q, input int ptol, input int ftol);
    exp_t e;
    int   ph;
    if (i == 0 && q == 0) ph = m_prev;
    else ph = rnd($atan2(real'(q), real'(i)) / TWO_PI * 65536.0) & 32'hFFFF;
    e.phase = ph;
    e.ptol  = ptol;
    e.freq  = m_prime ? ((ph - m_prev) & 32'hFFFF) : 0;
    e.ftol  = m_prime ? ftol : 0;
    e.mag   = rnd($sqrt(real'(i * i + q * q)));
    e.mtol  = (e.mag > 2048) ? 4 : 3;
    e.issue = cyc + 1;
    m_prev  = ph;
    m_prime = 1'b1;
    return e;
  endfunction

  // Called #1 after an edge: accepted on the next edge.
  task automatic drive(input int i, input int q, input int ptol, input int ftol);
    bus.in_valid = 1'b1;
    bus.i_in     = IW'(i);
    bus.q_in     = IW'(q);
    sb.push_back(model(i, q, ptol, ftol));
  endtask

  task automatic drain_check();
    #2;
    chk("result_seen", sb.size(), 0, 0);
    sb.delete();
  endtask

  // 20-cycle sample slot.
  task automatic send(input int i, input int q, input int ptol, input int ftol);
    @(posedge clk); #1;
    drive(i, q, ptol, ftol);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    drain_check();
  endtask

  task automatic phasor(input real start_deg, input real step_deg, input int n);
    real a;
    for (int s = 0; s < n; s++) begin
      a = (start_deg + step_deg * s) * DEG;
      send(rnd(1500.0 * $cos(a)), rnd(1500.0 * $sin(a)), 6, 8);
    end
  endtask

  initial begin : mon
    exp_t me;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.out_valid) begin
        ov_total++;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0, 0);
        end else begin
          me = sb.pop_front();
          chk("phase", int'(bus.phase_out), me.phase, me.ptol);
          chk("freq", int'(bus.freq_out), me.freq, me.ftol);
          chk("latency", cyc - me.issue, LAT, 0);
`ifdef IQ_FM_DISC_MAG_EN
          chk("mag", int'(bus.mag_out), me.mag, me.mtol);
`endif
        end
      end
    end
  end

  initial begin : stim
    int ov0;
    bus.in_valid = 1'b0;
    bus.i_in     = '0;
    bus.q_in     = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", int'(bus.phase_out), 0, 0);
    chk("rst_freq", int'(bus.freq_out), 0, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_overrun", int'(bus.overrun), 0, 0);
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
`ifdef IQ_FM_DISC_MAG_EN
    chk("rst_mag", int'(bus.mag_out), 0, 0);
`endif
    rst = 1'b0;
    ov0 = ov_total;
    repeat (30) @(posedge clk);
    #2;
    chk("idle_no_out", ov_total - ov0, 0, 0);

    for (int s = 0; s < 4; s++) send(1000, 0, 4, 4);

    phasor(0.0, 22.5, 32);
    phasor(0.0, -22.5, 32);

    // Back-to-back strobes: second one lands in PRE and is dropped.
    chk("overrun_before", int'(bus.overrun), 0, 0);
    @(posedge clk); #1;
    drive(700, 700, 4, 8);
    @(posedge clk); #1;
    bus.i_in = IW'(-300);
    bus.q_in = IW'(900);
    chk("in_ready_busy", int'(bus.in_ready), 0, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("overrun_set", int'(bus.overrun), 1, 0);
    repeat (LAT) @(posedge clk);
    drain_check();
    send(1000, 0, 4, 8);
    send(0, 1000, 4, 8);
    chk("overrun_sticky", int'(bus.overrun), 1, 0);

    send(-2048, 0, 4, 8);
    send(0, 0, 4, 0);
    send(-2048, -2048, 4, 8);
    send(1000, 0, 4, 8);

    // Reset while iterating aborts the sample and clears the prime flag.
    @(posedge clk); #1;
    drive(500, -800, 4, 8);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    m_prime = 1'b0;
    m_prev  = 0;
    ov0 = ov_total;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_overrun_clr", int'(bus.overrun), 0, 0);
    chk("abort_phase_clr", int'(bus.phase_out), 0, 0);
    chk("abort_in_ready", int'(bus.in_ready), 1, 0);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    chk("abort_no_out", ov_total - ov0, 0, 0);
    send(-1000, 1000, 4, 0);
    send(1000, 0, 4, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
